// File: rtl/store_buffer.sv
// Posted-write store buffer between core data port and single-port data memory.
// Define STORE_FWD_EN to forward load hits from the buffer; otherwise a hitting load stalls until drained.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_ce_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_data_i,
    output logic [DW-1:0] core_data_o,
    output logic          stall_o,
    output logic          mem_ce_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    input  logic [DW-1:0] mem_data_i,
    output logic          empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-3:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    logic          is_load, is_store;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic [PW-1:0] idx;
    logic          stall, fwd_hit;
    logic          nonempty, drain, load_go, push;

    assign is_load  = core_ce_i & ~core_we_i;
    assign is_store = core_ce_i &  core_we_i;
    assign nonempty = (count_q != '0);

    // Walk oldest to youngest so the last match left standing is the youngest entry.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (((PW+1)'(k) < count_q) && (addr_q[idx] == core_addr_i[AW-1:2])) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

`ifdef STORE_FWD_EN
    assign stall   = 1'b0;
    assign fwd_hit = ~rst & is_load & hit;
`else
    assign stall   = ~rst & is_load & hit;
    assign fwd_hit = 1'b0;
`endif

    assign drain   = ~rst & nonempty & (~is_load | stall);
    assign load_go = ~rst & is_load & ~stall;
    assign push    = ~rst & is_store & ((count_q < (PW+1)'(DEPTH)) | drain);

    assign stall_o     = stall;
    assign empty_o     = rst | ~nonempty;
    assign mem_ce_o    = load_go | drain;
    assign mem_we_o    = drain;
    assign mem_addr_o  = load_go ? core_addr_i
                       : drain  ? {addr_q[head_q], 2'b00}
                       : '0;
    assign mem_data_o  = drain ? data_q[head_q] : '0;
    assign core_data_o = fwd_hit ? hit_data : mem_data_i;

    always_comb begin
        head_d  = drain ? head_q + PW'(1) : head_q;
        tail_d  = push  ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({push, drain})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= core_addr_i[AW-1:2];
            data_q[tail_q] <= core_data_i;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// checked against a queue-based model of pending stores and a reference memory.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_ce_i, core_we_i;
    logic [31:0] core_addr_i, core_data_i;
    logic [31:0] core_data_o;
    logic        stall_o, mem_ce_o, mem_we_o, empty_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        fill_en;

    typedef struct {
        logic [7:0]  w;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];

    logic        last_stall;
    logic [31:0] last_core_data;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .core_ce_i(core_ce_i), .core_we_i(core_we_i),
        .core_addr_i(core_addr_i), .core_data_i(core_data_i),
        .core_data_o(core_data_o), .stall_o(stall_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .empty_o(empty_o)
    );

    function automatic logic [31:0] pattern(input int unsigned i);
        return 32'hC0DE_0000 | (i * 32'h0000_0101);
    endfunction

    assign mem_data_i = (mem_ce_o && !mem_we_o) ? mem[mem_addr_o[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else if (mem_ce_o && mem_we_o) begin
            mem[mem_addr_o[9:2]] <= mem_data_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One core cycle: drive, predict from pending-store queue, compare, then advance model.
    task automatic step(input logic r, input logic ce, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
        logic        ld, st, hit, stl, drn, ldgo;
        logic [31:0] fdata, exp_core, exp_addr, exp_wdata;
        rst = r; core_ce_i = ce; core_we_i = we; core_addr_i = a; core_data_i = d;
        #1;
        ld = ce && !we;
        st = ce && we;
        hit = 1'b0;
        fdata = '0;
        foreach (q[i]) if (q[i].w == a[9:2]) begin hit = 1'b1; fdata = q[i].d; end
        if (r) begin
            chk("rst_stall", {31'b0, stall_o}, 32'd0);
            chk("rst_empty", {31'b0, empty_o}, 32'd1);
            chk("rst_mem_ce", {31'b0, mem_ce_o}, 32'd0);
            chk("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
            chk("rst_core_data", core_data_o, 32'd0);
            last_stall = 1'b0;
        end else begin
`ifdef STORE_FWD_EN
            stl = 1'b0;
`else
            stl = ld && hit;
`endif
            drn  = (q.size() > 0) && (!ld || stl);
            ldgo = ld && !stl;
            exp_addr  = ldgo ? a : drn ? {22'b0, q[0].w, 2'b00} : 32'h0;
            exp_wdata = drn ? q[0].d : 32'h0;
            if (ld && hit && !stl)   exp_core = fdata;
            else if (ldgo)           exp_core = ref_mem[a[9:2]];
            else                     exp_core = 32'h0;
            chk("stall", {31'b0, stall_o}, {31'b0, stl});
            chk("empty", {31'b0, empty_o}, {31'b0, q.size() == 0});
            chk("mem_ce", {31'b0, mem_ce_o}, {31'b0, ldgo || drn});
            chk("mem_we", {31'b0, mem_we_o}, {31'b0, drn});
            chk("mem_addr", mem_addr_o, exp_addr);
            if (!ld) chk("mem_wdata", mem_data_o, exp_wdata);
            chk("core_data", core_data_o, exp_core);
            last_stall = stl;
            last_core_data = core_data_o;
        end
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (drn) begin
                ref_mem[q[0].w] = q[0].d;
                void'(q.pop_front());
            end
            if (st) q.push_back('{w: a[9:2], d: d});
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; core_ce_i = 1'b0; core_we_i = 1'b0;
        core_addr_i = '0; core_data_i = '0; fill_en = 1'b1;
        last_stall = 1'b0; last_core_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
        @(posedge clk);
        @(negedge clk);
        fill_en = 1'b0;

        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);

        step(0, 1, 1, 32'h100, 32'h11);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("mem_0x100", mem[8'h40], 32'h11);

        step(0, 1, 1, 32'h200, 32'hA);
        step(0, 1, 1, 32'h200, 32'hB);
        n = 0;
        step(0, 1, 0, 32'h200, 0);
        while (last_stall && n < 8) begin
            step(0, 1, 0, 32'h200, 0);
            n++;
        end
        chk("load_0x200_done", {31'b0, last_stall}, 32'd0);
        chk("load_0x200_data", last_core_data, 32'hB);

        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 32'h240 + 32'(i * 4), 32'h50 + 32'(i));
            step(0, 1, 0, 32'h300, 0);
        end
        step(0, 1, 1, 32'h250, 32'h55);
        step(0, 1, 1, 32'h280, 32'h61);
        step(0, 1, 1, 32'h284, 32'h62);
        step(0, 1, 0, 32'h300, 0);
        chk("load_0x300_data", last_core_data, pattern(32'hC0));
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        step(0, 1, 1, 32'h380, 32'h71);
        step(0, 1, 1, 32'h384, 32'h72);
        step(1, 1, 1, 32'h388, 32'h73);
        step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), a, $urandom);
        end
        repeat (6) step(0, 0, 0, 0, 0);

        for (int i = 0; i < 256; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
